// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux frame sequencer.
// States, widths and select-order helpers.
package mux_seq_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  function automatic logic [SEL_W-1:0] sel_first(
    input bit msb
  );
    return msb ? 3'd7 : 3'd0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_last(
    input bit msb
  );
    return msb ? 3'd0 : 3'd7;
  endfunction

endpackage

// File: rtl/mux_seq_divider.sv
// Bit-period counter for the mux frame sequencer.
// Pulses tc_o on the last clock of each bit period.
module mux_seq_divider #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W =
    (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [W-1:0] TC_V = W'(BIT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == TC_V);

  // Next count: wrap at terminal count, hold at 0 when cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_frame_sequencer.sv
// Serialises bytes through an external 8:1 mux by stepping its select.
// Optional parity slot when MUX_FRAME_PARITY_EN is defined.
module mux_frame_sequencer
  import mux_seq_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_y,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_last,
  output logic              busy
);

  localparam logic [SEL_W-1:0] FIRST_V =
    sel_first(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_V =
    sel_last(MSB_FIRST);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              bit_q, bit_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              tc;
  logic              accept;
  logic              last_slot;

  mux_seq_divider #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == IDLE),
    .en_i (state_q != IDLE),
    .tc_o (tc)
  );

  assign mux_in    = data_q;
  assign mux_sel   = sel_q;
  assign bit_out   = bit_q;
  assign bit_valid = vld_q;
  assign bit_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign last_slot = (sel_q == LAST_V);

  // Next state, slot sampling and handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    bit_d   = bit_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    s_ready = 1'b0;
    unique case (state_q)
      IDLE: s_ready = 1'b1;
      SHIFT: begin
        if (tc) begin
          bit_d = mux_y;
          vld_d = 1'b1;
          if (last_slot) begin
`ifdef MUX_FRAME_PARITY_EN
            state_d = PARITY;
`else
            last_d  = 1'b1;
            s_ready = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            sel_d = MSB_FIRST ? sel_q - 1'b1
                              : sel_q + 1'b1;
          end
        end
      end
`ifdef MUX_FRAME_PARITY_EN
      PARITY: begin
        if (tc) begin
          bit_d   = ^data_q;
          vld_d   = 1'b1;
          last_d  = 1'b1;
          s_ready = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    accept = s_valid && s_ready;
    if (accept) begin
      data_d  = s_data;
      sel_d   = FIRST_V;
      state_d = SHIFT;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux_frame_sequencer.sv
// Directed bench for mux_frame_sequencer.
// Three instances: BC=1 LSB-first, BC=1 MSB-first, BC=4 LSB-first.
module tb_mux_frame_sequencer;

`ifdef MUX_FRAME_PARITY_EN
  localparam int NS = 9;
`else
  localparam int NS = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] sd [3];
  logic       sv [3];
  logic       sr [3];
  logic [7:0] mi [3];
  logic [2:0] ms [3];
  logic       my [3];
  logic       bo [3];
  logic       bv [3];
  logic       bl [3];
  logic       bz [3];

  int vec;
  int errs;

  assign my[0] = mi[0][ms[0]];
  assign my[1] = mi[1][ms[1]];
  assign my[2] = mi[2][ms[2]];

  mux_frame_sequencer #(
    .BIT_CYCLES(1), .MSB_FIRST(1'b0)
  ) u_a (
    .clk(clk), .rst(rst),
    .s_data(sd[0]), .s_valid(sv[0]),
    .s_ready(sr[0]), .mux_in(mi[0]),
    .mux_sel(ms[0]), .mux_y(my[0]),
    .bit_out(bo[0]), .bit_valid(bv[0]),
    .bit_last(bl[0]), .busy(bz[0])
  );

  mux_frame_sequencer #(
    .BIT_CYCLES(1), .MSB_FIRST(1'b1)
  ) u_b (
    .clk(clk), .rst(rst),
    .s_data(sd[1]), .s_valid(sv[1]),
    .s_ready(sr[1]), .mux_in(mi[1]),
    .mux_sel(ms[1]), .mux_y(my[1]),
    .bit_out(bo[1]), .bit_valid(bv[1]),
    .bit_last(bl[1]), .busy(bz[1])
  );

  mux_frame_sequencer #(
    .BIT_CYCLES(4), .MSB_FIRST(1'b0)
  ) u_c (
    .clk(clk), .rst(rst),
    .s_data(sd[2]), .s_valid(sv[2]),
    .s_ready(sr[2]), .mux_in(mi[2]),
    .mux_sel(ms[2]), .mux_y(my[2]),
    .bit_out(bo[2]), .bit_valid(bv[2]),
    .bit_last(bl[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vec++;
      if (bv[d] !== 1'b0 || bl[d] !== 1'b0 ||
          bo[d] !== 1'b0 || bz[d] !== 1'b0 ||
          mi[d] !== 8'h00 || ms[d] !== 3'd0 ||
          sr[d] !== 1'b1) begin
        errs++;
        $display("FAIL reset[%0d]: got v%b l%b o%b b%b in%h sel%0d rdy%b want all 0, rdy 1",
                 d, bv[d], bl[d], bo[d], bz[d],
                 mi[d], ms[d], sr[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Accept one byte on instance d and check the whole frame.
  task automatic test_frame(
    input int         d,
    input logic [7:0] data,
    input int         bc,
    input bit         msb,
    input string      nm
  );
    logic [2:0] es;
    logic       eb;
    int         kk;
    sv[d] = 1'b1;
    sd[d] = data;
    vec++;
    if (sr[d] !== 1'b1) begin
      errs++;
      $display("FAIL %s idle_ready: got %b want 1",
               nm, sr[d]);
    end
    @(posedge clk);
    #1;
    sv[d] = 1'b0;
    sd[d] = 8'h00;
    vec++;
    if (bz[d] !== 1'b1 || mi[d] !== data ||
        bv[d] !== 1'b0) begin
      errs++;
      $display("FAIL %s start: got busy%b in%h v%b want 1 %h 0",
               nm, bz[d], mi[d], bv[d], data);
    end
    for (int k = 0; k < NS; k++) begin
      kk = (k > 7) ? 7 : k;
      es = msb ? 3'(7 - kk) : 3'(kk);
      for (int c = 1; c <= bc; c++) begin
        vec++;
        if (ms[d] !== es ||
            sr[d] !== ((k == NS-1) && (c == bc))) begin
          errs++;
          $display("FAIL %s slot%0d cyc%0d: got sel%0d rdy%b want sel%0d rdy%b",
                   nm, k, c, ms[d], sr[d], es,
                   (k == NS-1) && (c == bc));
        end
        @(posedge clk);
        #1;
        if (c < bc) begin
          vec++;
          if (bv[d] !== 1'b0) begin
            errs++;
            $display("FAIL %s gap%0d: got valid %b want 0",
                     nm, k, bv[d]);
          end
        end
      end
      eb = (k == 8) ? ^data : data[msb ? 7-k : k];
      vec++;
      if (bv[d] !== 1'b1 || bo[d] !== eb ||
          bl[d] !== (k == NS-1)) begin
        errs++;
        $display("FAIL %s strobe%0d: got v%b o%b l%b want 1 %b %b",
                 nm, k, bv[d], bo[d], bl[d], eb,
                 k == NS-1);
      end
    end
    @(posedge clk);
    #1;
    es = msb ? 3'd0 : 3'd7;
    vec++;
    if (bv[d] !== 1'b0 || bl[d] !== 1'b0 ||
        bz[d] !== 1'b0 || sr[d] !== 1'b1 ||
        ms[d] !== es) begin
      errs++;
      $display("FAIL %s end: got v%b l%b b%b r%b sel%0d want 0 0 0 1 %0d",
               nm, bv[d], bl[d], bz[d], sr[d],
               ms[d], es);
    end
  endtask

  task automatic test_lsb_first();
    test_frame(0, 8'hA5, 1, 1'b0, "lsb_a5");
  endtask

  task automatic test_msb_first();
    test_frame(1, 8'h80, 1, 1'b1, "msb_80");
    test_frame(1, 8'h6C, 1, 1'b1, "msb_6c");
  endtask

  task automatic test_slow_rate();
    test_frame(2, 8'h3C, 4, 1'b0, "bc4_3c");
  endtask

  task automatic test_back_to_back();
    logic eb;
    sv[0] = 1'b1;
    sd[0] = 8'h01;
    @(posedge clk);
    #1;
    sd[0] = 8'hFF;
    for (int j = 0; j < 2*NS; j++) begin
      @(posedge clk);
      #1;
      if (j < NS)
        eb = (j == 8) ? 1'b1 : (j == 0);
      else
        eb = (j - NS == 8) ? 1'b0 : 1'b1;
      vec++;
      if (bv[0] !== 1'b1 || bo[0] !== eb ||
          bl[0] !== (j == NS-1 || j == 2*NS-1)) begin
        errs++;
        $display("FAIL b2b strobe%0d: got v%b o%b l%b want 1 %b %b",
                 j, bv[0], bo[0], bl[0], eb,
                 j == NS-1 || j == 2*NS-1);
      end
      if (j == NS-1) begin
        sv[0] = 1'b0;
        vec++;
        if (mi[0] !== 8'hFF || bz[0] !== 1'b1) begin
          errs++;
          $display("FAIL b2b reload: got in%h busy%b want ff 1",
                   mi[0], bz[0]);
        end
      end
    end
    @(posedge clk);
    #1;
    vec++;
    if (bv[0] !== 1'b0 || bz[0] !== 1'b0) begin
      errs++;
      $display("FAIL b2b end: got v%b busy%b want 0 0",
               bv[0], bz[0]);
    end
  endtask

  task automatic test_reset_abort();
    sv[0] = 1'b1;
    sd[0] = 8'hF0;
    @(posedge clk);
    #1;
    sv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    vec++;
    if (bv[0] !== 1'b1 || bo[0] !== 1'b0) begin
      errs++;
      $display("FAIL abort pre: got v%b o%b want 1 0",
               bv[0], bo[0]);
    end
    rst   = 1'b1;
    sv[0] = 1'b1;
    sd[0] = 8'hAA;
    @(posedge clk);
    #1;
    vec++;
    if (bv[0] !== 1'b0 || bl[0] !== 1'b0 ||
        bo[0] !== 1'b0 || bz[0] !== 1'b0 ||
        mi[0] !== 8'h00 || ms[0] !== 3'd0 ||
        sr[0] !== 1'b1) begin
      errs++;
      $display("FAIL abort rst: got v%b l%b o%b b%b in%h sel%0d r%b want 0s, r1",
               bv[0], bl[0], bo[0], bz[0], mi[0],
               ms[0], sr[0]);
    end
    rst   = 1'b0;
    sv[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      vec++;
      if (bv[0] !== 1'b0 || bz[0] !== 1'b0) begin
        errs++;
        $display("FAIL abort quiet%0d: got v%b b%b want 0 0",
                 i, bv[0], bz[0]);
      end
    end
    test_frame(0, 8'h5A, 1, 1'b0, "post_rst_5a");
  endtask

  task automatic test_parity();
    test_frame(0, 8'h07, 1, 1'b0, "par_07");
    test_frame(0, 8'h03, 1, 1'b0, "par_03");
    test_frame(2, 8'h07, 4, 1'b0, "par_bc4_07");
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rst  = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sv[d] = 1'b0;
      sd[d] = 8'h00;
    end
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_slow_rate();
    test_back_to_back();
    test_reset_abort();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule

// File: doc/mux_frame_sequencer.md
Name: mux_frame_sequencer

Overview:
- Upstream controller for the team's 8:1 single-bit mux stage.
- Accepts one byte per frame over a valid/ready handshake and holds it on the mux data lines.
- Steps the 3-bit select through all 8 indices at a programmable bit rate, samples the mux output and emits a serial bit stream with per-bit strobe and last-bit flag.
- Sits between the byte-producing datapath and the 8:1 mux; the mux output feeds back into this block.

Parameters:
- BIT_CYCLES, 1, clocks each select value is held (bit period); legal range 1..256.
- MSB_FIRST, 0, 0 = select order 0→7; 1 = select order 7→0.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  8  byte to serialise.
- s_valid  input  1  s_data valid.
- s_ready  output  1  block can accept a byte this cycle.
- mux_in  output  8  held byte, drives mux data inputs.
- mux_sel  output  3  drives mux select.
- mux_y  input  1  mux output (combinational from mux_in/mux_sel).
- bit_out  output  1  sampled serial bit.
- bit_valid  output  1  one-cycle strobe, bit_out valid.
- bit_last  output  1  high with bit_valid on the final bit of a frame.
- busy  output  1  frame in progress.

Behaviour:
- Clock and reset: single clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE, mux_in=0, mux_sel=0, bit_out=0, bit_valid=0, bit_last=0, busy=0, divider=0.
- Divider width: max(1, clog2(BIT_CYCLES)).
- States: IDLE, SHIFT, PARITY (PARITY only when the optional feature is compiled in).
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready: mux_in<=s_data; mux_sel<=MSB_FIRST?7:0; divider<=0; index count<=0; next state SHIFT.
- SHIFT:
  - busy=1. Divider increments each cycle.
  - When divider==BIT_CYCLES-1:
    - bit_out<=mux_y, bit_valid<=1 for exactly the next cycle.
    - mux_sel advances by ±1; 3-bit wrap is never observable within a frame.
    - divider<=0.
  - On the 8th sample: bit_last<=1 (unless PARITY_EN), then go to IDLE.
- Sampling latency: the byte accepted at edge T yields its first bit_valid in the cycle after edge T+BIT_CYCLES. Strobes are spaced exactly BIT_CYCLES cycles apart.
- Gapless streaming:
  - s_ready is also 1 during the final divider cycle of the last slot of a frame (last data slot, or parity slot when enabled).
  - A byte accepted there starts the next frame immediately in SHIFT, with no idle cycle between frames.
- s_ready=0 at all other times in SHIFT/PARITY; s_data is ignored then.
- mux_in is stable for the whole frame. mux_sel changes only at slot boundaries.
- After the last slot, mux_sel holds its last value until the next accept.
- Reset mid-frame: abort immediately, no further bit_valid, all outputs return to reset values on the next edge.
- rst has priority over a simultaneous handshake.

Optional Feature:
- Macro: MUX_FRAME_PARITY_EN.
- Defined:
  - After the 8th data slot, enter PARITY for BIT_CYCLES clocks.
  - Emit bit_out = even parity (XOR of mux_in) with bit_valid at the same cadence.
  - bit_last moves from the 8th data bit to the parity bit.
  - Frame length is 9 slots.
- Undefined: PARITY state absent; 8-slot frames; no parity logic synthesised.

Decomposition:
- Shared package mux_seq_pkg:
  - state enum {IDLE, SHIFT, PARITY}
  - constant SEL_W=3
  - constant DATA_W=8
  - constant SEL_FIRST/SEL_LAST helper values derived from MSB_FIRST.
- Sub-module mux_seq_divider: a bit-period counter with a terminal-count pulse, parameterised by BIT_CYCLES. All other logic lives in the top.

Test Plan:
1. BIT_CYCLES=1, MSB_FIRST=0, accept 0xA5 at edge T → bit_valid on 8 consecutive cycles starting after T+1; bits 1,0,1,0,0,1,0,1; bit_last only on the 8th; mux_sel 0..7.
2. MSB_FIRST=1, accept 0x80 → bits 1,0,0,0,0,0,0,0; mux_sel sequence 7,6,...,0.
3. BIT_CYCLES=4, accept 0x3C → bit_valid exactly every 4 cycles; mux_sel changes only every 4 cycles; s_ready=0 until the last divider cycle of slot 8.
4. Stream 0x01 then 0xFF with s_valid held high → 16 strobes with no gap; bit_last on strobes 8 and 16; bits 1,0×7 then 1×8.
5. Assert rst after the 3rd strobe of 0xF0 → no further bit_valid; all outputs 0 next cycle; s_ready=1; a fresh byte is accepted normally.
6. MUX_FRAME_PARITY_EN defined, accept 0x07 → 9 strobes; 9th bit_out=1 with bit_last; 0x03 → parity bit 0.
